pe_stream_cell: RTL and testbench

- Next-generation systolic processing element for the matrix-multiply array.
- Consumes paired A/B operand streams over valid/ready handshakes and forwards them east (A) and south (B) through registered pass-through stages.
- Accumulates signed fixed-point products into a bank of 2^ACC_NUM_WIDTH local accumulators, with optional saturation.
- After K rounds, drains the results through a handshaked result port.

---
 rtl/pe_stream_cell.sv | 191 +++++++++++++++++++
 tb/tb_pe_stream_cell.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_cell.sv
// Systolic MAC cell. It forwards the A/B operand streams east and south, accumulates
// their products into a small bank of local accumulators, and drains the results after K rounds.
module pe_stream_cell #(
  parameter int unsigned D_WIDTH       = 16,
  parameter int unsigned ACC_WIDTH     = 40,
  parameter int unsigned ACC_NUM_WIDTH = 2,
  parameter int unsigned K_WIDTH       = 16,
  parameter bit          SATURATE      = 1'b1,
  parameter int unsigned PID           = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic [K_WIDTH-1:0]       K_in,
  input  logic [D_WIDTH-1:0]       a_data_in,
  input  logic                     a_valid_in,
  output logic                     a_ready_out,
  input  logic [D_WIDTH-1:0]       b_data_in,
  input  logic                     b_valid_in,
  output logic                     b_ready_out,
  output logic [D_WIDTH-1:0]       a_data_out,
  output logic                     a_valid_out,
  input  logic                     a_ready_in,
  output logic [D_WIDTH-1:0]       b_data_out,
  output logic                     b_valid_out,
  input  logic                     b_ready_in,
  output logic [ACC_WIDTH-1:0]     res_data_out,
  output logic [ACC_NUM_WIDTH-1:0] res_idx_out,
  output logic                     res_valid_out,
  input  logic                     res_ready_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     overflow_out,
  output logic [7:0]               pid_out
);

  localparam int unsigned NUM_ACC = 1 << ACC_NUM_WIDTH;
  localparam int unsigned P_WIDTH = 2 * D_WIDTH;
  localparam int unsigned S_WIDTH = ACC_WIDTH + 1;
  localparam logic [ACC_NUM_WIDTH-1:0] LAST_IDX = ACC_NUM_WIDTH'(NUM_ACC - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t                          state;
  logic [K_WIDTH-1:0]              k_target;
  logic [K_WIDTH-1:0]              k_cnt;
  logic [ACC_NUM_WIDTH-1:0]        idx;
  logic signed [ACC_WIDTH-1:0]     acc [NUM_ACC];

  logic                            s1_valid;
  logic signed [D_WIDTH-1:0]       s1_a;
  logic signed [D_WIDTH-1:0]       s1_b;
  logic [ACC_NUM_WIDTH-1:0]        s1_idx;
  logic                            s2_valid;
  logic signed [ACC_WIDTH-1:0]     s2_prod;
  logic [ACC_NUM_WIDTH-1:0]        s2_idx;

  logic                            space_a;
  logic                            space_b;
  logic                            fire;
  logic                            last_pair;
  logic                            drain_done;
  logic [ACC_NUM_WIDTH-1:0]        res_idx_nxt;
  logic signed [P_WIDTH-1:0]       prod_full;
  logic signed [S_WIDTH-1:0]       acc_sum;
  logic                            acc_ovf;
  logic signed [ACC_WIDTH-1:0]     acc_next;

  // A pair is only taken when both forward registers can accept it in the same cycle.
  assign space_a     = !a_valid_out || a_ready_in;
  assign space_b     = !b_valid_out || b_ready_in;
  assign fire        = (state == RUN) && a_valid_in && b_valid_in && space_a && space_b;
  assign a_ready_out = (state == RUN) && b_valid_in && space_a && space_b;
  assign b_ready_out = (state == RUN) && a_valid_in && space_a && space_b;
  assign last_pair   = (idx == LAST_IDX) && (k_cnt == k_target - K_WIDTH'(1));
  assign drain_done  = (state == DRAIN) && res_valid_out && res_ready_in && (res_idx_out == LAST_IDX);
  assign res_idx_nxt = res_idx_out + ACC_NUM_WIDTH'(1);
  assign busy_out    = (state != IDLE);
  assign pid_out     = 8'(PID);

  // One extra sum bit exposes signed overflow; clamp or wrap as configured.
  assign prod_full = P_WIDTH'(s1_a) * P_WIDTH'(s1_b);
  assign acc_sum   = S_WIDTH'(acc[s2_idx]) + S_WIDTH'(s2_prod);
  assign acc_ovf   = acc_sum[S_WIDTH-1] ^ acc_sum[S_WIDTH-2];
  assign acc_next  = (SATURATE && acc_ovf) ? (acc_sum[S_WIDTH-1] ? ~ACC_MAX : ACC_MAX)
                                           : acc_sum[ACC_WIDTH-1:0];

  // Accumulator bank: S3 write, bulk clear when the final result is handed off.
  always_ff @(posedge clk) begin
    if (!rst || drain_done) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else if (s2_valid) begin
      acc[s2_idx] <= acc_next;
    end
  end

  // Control, forwarding, MAC pipeline S1/S2 and result port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      k_target      <= '0;
      k_cnt         <= '0;
      idx           <= '0;
      a_data_out    <= '0;
      a_valid_out   <= 1'b0;
      b_data_out    <= '0;
      b_valid_out   <= 1'b0;
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_idx        <= '0;
      s2_valid      <= 1'b0;
      s2_prod       <= '0;
      s2_idx        <= '0;
      res_data_out  <= '0;
      res_idx_out   <= '0;
      res_valid_out <= 1'b0;
      done_out      <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;

      if (fire) begin
        a_data_out  <= a_data_in;
        a_valid_out <= 1'b1;
        b_data_out  <= b_data_in;
        b_valid_out <= 1'b1;
      end else begin
        if (a_ready_in) a_valid_out <= 1'b0;
        if (b_ready_in) b_valid_out <= 1'b0;
      end

      s1_valid <= fire;
      if (fire) begin
        s1_a   <= a_data_in;
        s1_b   <= b_data_in;
        s1_idx <= idx;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= ACC_WIDTH'(prod_full);
        s2_idx  <= s1_idx;
      end
      if (s2_valid && acc_ovf) overflow_out <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start_in) begin
            k_target     <= K_in;
            k_cnt        <= '0;
            idx          <= '0;
            overflow_out <= 1'b0;
            state        <= (K_in == '0) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (fire) begin
            idx <= idx + ACC_NUM_WIDTH'(1);
            if (idx == LAST_IDX) k_cnt <= k_cnt + K_WIDTH'(1);
            if (last_pair) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!s1_valid && !s2_valid) begin
            state         <= DRAIN;
            res_valid_out <= 1'b1;
            res_idx_out   <= '0;
            res_data_out  <= acc[0];
          end
        end
        DRAIN: begin
          if (res_valid_out && res_ready_in) begin
            if (res_idx_out == LAST_IDX) begin
              res_valid_out <= 1'b0;
              res_idx_out   <= '0;
              res_data_out  <= '0;
              done_out      <= 1'b1;
              state         <= IDLE;
            end else begin
              res_idx_out  <= res_idx_nxt;
              res_data_out <= acc[res_idx_nxt];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream_cell.sv
// Bench for pe_stream_cell: three instances (40-bit saturating, 32-bit saturating, 32-bit wrapping)
// share one stimulus and are checked against a job-level arithmetic model.
module tb_pe_stream_cell;

  localparam int unsigned K_WIDTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start_in;
  logic [K_WIDTH-1:0] k_in;
  logic [15:0]        a_data_in, b_data_in;
  logic               a_valid_in, b_valid_in, a_ready_in, b_ready_in, res_ready_in;

  logic        a_ready_out [3], b_ready_out [3], a_valid_out [3], b_valid_out [3];
  logic        res_valid_out [3], busy_out [3], done_out [3], overflow_out [3];
  logic [15:0] a_data_out [3], b_data_out [3];
  logic [1:0]  res_idx_out [3];
  logic [7:0]  pid_out [3];
  logic [39:0] res40;
  logic [31:0] res_s32, res_w32;

  pe_stream_cell #(.PID(0)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .K_in(k_in),
    .a_data_in(a_data_in), .a_valid_in(a_valid_in), .a_ready_out(a_ready_out[0]),
    .b_data_in(b_data_in), .b_valid_in(b_valid_in), .b_ready_out(b_ready_out[0]),
    .a_data_out(a_data_out[0]), .a_valid_out(a_valid_out[0]), .a_ready_in(a_ready_in),
    .b_data_out(b_data_out[0]), .b_valid_out(b_valid_out[0]), .b_ready_in(b_ready_in),
    .res_data_out(res40), .res_idx_out(res_idx_out[0]), .res_valid_out(res_valid_out[0]),
    .res_ready_in(res_ready_in), .busy_out(busy_out[0]), .done_out(done_out[0]),
    .overflow_out(overflow_out[0]), .pid_out(pid_out[0]));

  pe_stream_cell #(.ACC_WIDTH(32), .SATURATE(1'b1), .PID(1)) dut_s32 (
    .clk(clk), .rst(rst), .start_in(start_in), .K_in(k_in),
    .a_data_in(a_data_in), .a_valid_in(a_valid_in), .a_ready_out(a_ready_out[1]),
    .b_data_in(b_data_in), .b_valid_in(b_valid_in), .b_ready_out(b_ready_out[1]),
    .a_data_out(a_data_out[1]), .a_valid_out(a_valid_out[1]), .a_ready_in(a_ready_in),
    .b_data_out(b_data_out[1]), .b_valid_out(b_valid_out[1]), .b_ready_in(b_ready_in),
    .res_data_out(res_s32), .res_idx_out(res_idx_out[1]), .res_valid_out(res_valid_out[1]),
    .res_ready_in(res_ready_in), .busy_out(busy_out[1]), .done_out(done_out[1]),
    .overflow_out(overflow_out[1]), .pid_out(pid_out[1]));

  pe_stream_cell #(.ACC_WIDTH(32), .SATURATE(1'b0), .PID(2)) dut_w32 (
    .clk(clk), .rst(rst), .start_in(start_in), .K_in(k_in),
    .a_data_in(a_data_in), .a_valid_in(a_valid_in), .a_ready_out(a_ready_out[2]),
    .b_data_in(b_data_in), .b_valid_in(b_valid_in), .b_ready_out(b_ready_out[2]),
    .a_data_out(a_data_out[2]), .a_valid_out(a_valid_out[2]), .a_ready_in(a_ready_in),
    .b_data_out(b_data_out[2]), .b_valid_out(b_valid_out[2]), .b_ready_in(b_ready_in),
    .res_data_out(res_w32), .res_idx_out(res_idx_out[2]), .res_valid_out(res_valid_out[2]),
    .res_ready_in(res_ready_in), .busy_out(busy_out[2]), .done_out(done_out[2]),
    .overflow_out(overflow_out[2]), .pid_out(pid_out[2]));

  int     n_vec = 0;
  int     n_err = 0;
  int     qa[$], qb[$], fa[$], fb[$], gidx[$];
  longint g40[$], gs[$], gw[$];
  longint e40[4], es[4], ew[4];
  bit     eo40, eos, eow, tmo;
  int     nfire, first_fire, last_fire, done_cnt, busy_bad, prot_err, stall_err;

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 5) == 0) v = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
    return int'(v);
  endfunction

  // One accumulate step on an ideal integer, then bring it back into a w-bit signed range.
  function automatic void acc_step(inout longint acc, input longint p, input int w,
                                   input bit sat, inout bit ovf);
    longint mx, mn, s;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    s  = acc + p;
    if (s > mx || s < mn) begin
      ovf = 1'b1;
      if (sat) s = (s > mx) ? mx : mn;
      else     s = (s > mx) ? s - (2 * mx + 2) : s + (2 * mx + 2);
    end
    acc = s;
  endfunction

  // Pair i lands in accumulator i mod 4, in stream order.
  task automatic model_job();
    longint p;
    for (int i = 0; i < 4; i++) begin e40[i] = 0; es[i] = 0; ew[i] = 0; end
    eo40 = 0; eos = 0; eow = 0;
    for (int i = 0; i < qa.size(); i++) begin
      p = longint'(qa[i]) * longint'(qb[i]);
      acc_step(e40[i % 4], p, 40, 1'b1, eo40);
      acc_step(es[i % 4],  p, 32, 1'b1, eos);
      acc_step(ew[i % 4],  p, 32, 1'b0, eow);
    end
  endtask

  // Runs one job from start to done (or to abort_at fires); records what the DUT delivered.
  task automatic run_job(input int k, input bit rnd, input int res_mode, input int stall_at,
                         input int stall_len, input int start_at, input int abort_at);
    int sent, cyc, stall_left, post, total;
    bit stalled, extra_start, in_stall, want, afire, bfire, pa, pb, pr;
    logic [15:0] pad, pbd;
    logic [1:0]  pri;
    logic [39:0] prd;
    sent = 0; cyc = 0; stall_left = 0; post = -1; total = 4 * k;
    stalled = 0; extra_start = 0; pa = 0; pb = 0; pr = 0; pad = '0; pbd = '0; pri = '0; prd = '0;
    fa.delete(); fb.delete(); gidx.delete(); g40.delete(); gs.delete(); gw.delete();
    nfire = 0; first_fire = 0; last_fire = 0; done_cnt = 0; busy_bad = 0; prot_err = 0;
    stall_err = 0; tmo = 1;
    @(negedge clk);
    start_in = 1; k_in = K_WIDTH'(k); a_valid_in = 0; b_valid_in = 0;
    a_ready_in = 1; b_ready_in = 1; res_ready_in = 0;
    @(negedge clk);
    while (cyc < 3000) begin
      cyc++;
      start_in = 0;
      if (start_at >= 0 && nfire == start_at && !extra_start) begin
        start_in = 1; k_in = K_WIDTH'(7); extra_start = 1;
      end
      want = (post < 0) && (k == 0 || sent < total);
      a_valid_in = want && (!rnd || $urandom_range(0, 3) != 0);
      b_valid_in = a_valid_in;
      if (rnd && want && $urandom_range(0, 7) == 0) b_valid_in = !a_valid_in;
      a_data_in = (sent < total) ? 16'(qa[sent]) : 16'($urandom);
      b_data_in = (sent < total) ? 16'(qb[sent]) : 16'($urandom);
      in_stall = (stall_left > 0);
      if (in_stall) stall_left--;
      a_ready_in = !in_stall && (post >= 0 || !rnd || $urandom_range(0, 3) != 0);
      b_ready_in = post >= 0 || !rnd || $urandom_range(0, 3) != 0;
      if (post >= 0 || res_mode == 0) res_ready_in = 1;
      else if (res_mode == 1)         res_ready_in = !res_ready_in;
      else                            res_ready_in = $urandom_range(0, 1) != 0;
      #1;
      afire = a_valid_in && a_ready_out[0];
      bfire = b_valid_in && b_ready_out[0];
      if (afire != bfire) prot_err++;
      if (afire && bfire) begin
        sent++; nfire++;
        if (nfire == 1) first_fire = cyc;
        last_fire = cyc;
      end
      if (pa && (a_valid_out[0] !== 1'b1 || a_data_out[0] !== pad)) prot_err++;
      if (pb && (b_valid_out[0] !== 1'b1 || b_data_out[0] !== pbd)) prot_err++;
      if (pr && (res_valid_out[0] !== 1'b1 || res_idx_out[0] !== pri || res40 !== prd)) prot_err++;
      pa = a_valid_out[0] && !a_ready_in;   pad = a_data_out[0];
      pb = b_valid_out[0] && !b_ready_in;   pbd = b_data_out[0];
      pr = res_valid_out[0] && !res_ready_in; pri = res_idx_out[0]; prd = res40;
      if (a_valid_out[0] && a_ready_in) fa.push_back(int'($signed(a_data_out[0])));
      if (b_valid_out[0] && b_ready_in) fb.push_back(int'($signed(b_data_out[0])));
      if (res_valid_out[0] && res_ready_in) begin
        gidx.push_back(int'(res_idx_out[0]));
        g40.push_back(longint'($signed(res40)));
        gs.push_back(longint'($signed(res_s32)));
        gw.push_back(longint'($signed(res_w32)));
      end
      if (in_stall && (a_ready_out[0] || b_ready_out[0] || !a_valid_out[0])) stall_err++;
      if (stall_at >= 0 && !stalled && afire && nfire == stall_at) begin
        stalled = 1; stall_left = stall_len;
      end
      if (done_out[0]) begin
        done_cnt++;
        if (busy_out[0]) busy_bad++;
        if (post < 0) post = 4;
      end
      if (post > 0) post--;
      if (post == 0 || (abort_at >= 0 && nfire == abort_at)) begin
        tmo = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 0; start_in = 1; k_in = 3; a_valid_in = 1; b_valid_in = 1;
    a_data_in = 16'h1234; b_data_in = 16'h5678; a_ready_in = 0; b_ready_in = 0; res_ready_in = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({a_valid_out[0], b_valid_out[0], res_valid_out[0], done_out[0], overflow_out[0],
         busy_out[0], a_ready_out[0], b_ready_out[0]} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000000", {a_valid_out[0], b_valid_out[0],
               res_valid_out[0], done_out[0], overflow_out[0], busy_out[0], a_ready_out[0], b_ready_out[0]});
    end
    n_vec++;
    if ({a_data_out[0], b_data_out[0], res40, res_idx_out[0]} !== 74'd0) begin
      n_err++;
      $display("FAIL reset_data: got a=%h b=%h res=%h idx=%0d want 0", a_data_out[0], b_data_out[0],
               res40, res_idx_out[0]);
    end
    n_vec++;
    if (pid_out[0] !== 8'd0 || pid_out[1] !== 8'd1 || pid_out[2] !== 8'd2) begin
      n_err++;
      $display("FAIL pid: got %0d/%0d/%0d want 0/1/2", pid_out[0], pid_out[1], pid_out[2]);
    end
    @(negedge clk);
    start_in = 0; a_valid_in = 0; b_valid_in = 0; a_ready_in = 1; b_ready_in = 1; rst = 1;
    @(negedge clk);
    #1;
    n_vec++;
    if (busy_out[0] !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: busy got %b want 0", busy_out[0]);
    end
  endtask

  task automatic test_k1_directed();
    int bad;
    qa = '{3, 3, 3, 3};
    qb = '{2, -1, 5, 7};
    model_job();
    run_job(1, 0, 0, -1, 0, -1, -1);
    n_vec++;
    if (tmo !== 1'b0) begin n_err++; $display("FAIL k1_timeout: got %b want 0", tmo); end
    n_vec++;
    if (g40.size() != 4) begin n_err++; $display("FAIL k1_count: got %0d want 4", g40.size()); end
    for (int i = 0; i < 4 && i < int'(g40.size()); i++) begin
      n_vec++;
      if (gidx[i] !== i || g40[i] !== e40[i] || gs[i] !== es[i] || gw[i] !== ew[i]) begin
        n_err++;
        $display("FAIL k1_res[%0d]: got idx %0d %0d/%0d/%0d want idx %0d %0d/%0d/%0d", i, gidx[i],
                 g40[i], gs[i], gw[i], i, e40[i], es[i], ew[i]);
      end
    end
    bad = (fa.size() != 4 || fb.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4 && i < int'(fa.size()) && i < int'(fb.size()); i++)
      if (fa[i] != qa[i] || fb[i] != qb[i]) bad++;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL k1_forward: got %0d bad entries want 0", bad); end
    n_vec++;
    if (done_cnt !== 1 || busy_bad !== 0) begin
      n_err++; $display("FAIL k1_done: got pulses %0d busy_at_done %0d want 1/0", done_cnt, busy_bad);
    end
  endtask

  task automatic test_back_to_back();
    qa = '{1, 2, 3, 4, 5, 6, 7, 8};
    qb = '{1, 2, 3, 4, 1, 2, 3, 4};
    model_job();
    run_job(2, 0, 0, -1, 0, -1, -1);
    n_vec++;
    if (tmo !== 1'b0 || nfire !== 8 || last_fire - first_fire !== 7) begin
      n_err++;
      $display("FAIL b2b_rate: got tmo %b fires %0d span %0d want 0/8/7", tmo, nfire, last_fire - first_fire);
    end
    n_vec++;
    if (g40.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", g40.size()); end
    for (int i = 0; i < 4 && i < int'(g40.size()); i++) begin
      n_vec++;
      if (gidx[i] !== i || g40[i] !== e40[i] || gs[i] !== es[i] || gw[i] !== ew[i]) begin
        n_err++;
        $display("FAIL b2b_res[%0d]: got idx %0d %0d/%0d/%0d want idx %0d %0d/%0d/%0d", i, gidx[i],
                 g40[i], gs[i], gw[i], i, e40[i], es[i], ew[i]);
      end
    end
    n_vec++;
    if (prot_err !== 0 || done_cnt !== 1) begin
      n_err++; $display("FAIL b2b_proto: got errors %0d pulses %0d want 0/1", prot_err, done_cnt);
    end
  endtask

  task automatic test_stall();
    int bad;
    qa = '{1, 2, 3, 4, 5, 6, 7, 8};
    qb = '{1, 2, 3, 4, 1, 2, 3, 4};
    model_job();
    run_job(2, 0, 0, 3, 5, -1, -1);
    n_vec++;
    if (tmo !== 1'b0 || nfire !== 8 || last_fire - first_fire !== 12) begin
      n_err++;
      $display("FAIL stall_rate: got tmo %b fires %0d span %0d want 0/8/12", tmo, nfire, last_fire - first_fire);
    end
    n_vec++;
    if (stall_err !== 0 || prot_err !== 0) begin
      n_err++; $display("FAIL stall_hold: got stall errors %0d protocol errors %0d want 0/0", stall_err, prot_err);
    end
    bad = (fa.size() != 8 || fb.size() != 8 || g40.size() != 4) ? 1 : 0;
    for (int i = 0; i < 8 && i < int'(fa.size()) && i < int'(fb.size()); i++)
      if (fa[i] != qa[i] || fb[i] != qb[i]) bad++;
    for (int i = 0; i < 4 && i < int'(g40.size()); i++)
      if (gidx[i] != i || g40[i] != e40[i] || gs[i] != es[i] || gw[i] != ew[i]) bad++;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL stall_data: got %0d bad entries want 0", bad); end
  endtask

  task automatic test_saturate();
    qa.delete(); qb.delete();
    for (int i = 0; i < 12; i++) begin qa.push_back(32767); qb.push_back(32767); end
    model_job();
    run_job(3, 1, 2, -1, 0, -1, -1);
    n_vec++;
    if (tmo !== 1'b0 || g40.size() != 4) begin
      n_err++; $display("FAIL sat_count: got tmo %b results %0d want 0/4", tmo, g40.size());
    end
    for (int i = 0; i < 4 && i < int'(g40.size()); i++) begin
      n_vec++;
      if (gidx[i] !== i || g40[i] !== e40[i] || gs[i] !== es[i] || gw[i] !== ew[i]) begin
        n_err++;
        $display("FAIL sat_res[%0d]: got idx %0d %0d/%0d/%0d want idx %0d %0d/%0d/%0d", i, gidx[i],
                 g40[i], gs[i], gw[i], i, e40[i], es[i], ew[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (overflow_out[0] !== eo40 || overflow_out[1] !== eos || overflow_out[2] !== eow) begin
      n_err++;
      $display("FAIL sat_overflow: got %b%b%b want %b%b%b", overflow_out[0], overflow_out[1],
               overflow_out[2], eo40, eos, eow);
    end
  endtask

  task automatic test_k0();
    qa.delete(); qb.delete();
    model_job();
    run_job(0, 0, 1, -1, 0, -1, -1);
    n_vec++;
    if (tmo !== 1'b0 || nfire !== 0) begin
      n_err++; $display("FAIL k0_stream: got tmo %b fires %0d want 0/0", tmo, nfire);
    end
    n_vec++;
    if (g40.size() != 4) begin n_err++; $display("FAIL k0_count: got %0d want 4", g40.size()); end
    for (int i = 0; i < 4 && i < int'(g40.size()); i++) begin
      n_vec++;
      if (gidx[i] !== i || g40[i] !== e40[i] || gs[i] !== es[i] || gw[i] !== ew[i]) begin
        n_err++;
        $display("FAIL k0_res[%0d]: got idx %0d %0d/%0d/%0d want idx %0d 0/0/0", i, gidx[i],
                 g40[i], gs[i], gw[i], i);
      end
    end
    n_vec++;
    if (prot_err !== 0 || done_cnt !== 1) begin
      n_err++; $display("FAIL k0_proto: got errors %0d pulses %0d want 0/1", prot_err, done_cnt);
    end
    n_vec++;
    if (overflow_out[0] !== 1'b0 || overflow_out[1] !== 1'b0 || overflow_out[2] !== 1'b0) begin
      n_err++;
      $display("FAIL k0_ovf_clear: got %b%b%b want 000", overflow_out[0], overflow_out[1], overflow_out[2]);
    end
  endtask

  task automatic test_start_ignored_and_abort();
    int bad;
    qa.delete(); qb.delete();
    for (int i = 0; i < 8; i++) begin qa.push_back(rnd16()); qb.push_back(rnd16()); end
    model_job();
    run_job(2, 1, 2, -1, 0, 2, -1);
    bad = (tmo || g40.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4 && i < int'(g40.size()); i++)
      if (gidx[i] != i || g40[i] != e40[i] || gs[i] != es[i] || gw[i] != ew[i]) bad++;
    n_vec++;
    if (bad !== 0 || done_cnt !== 1) begin
      n_err++; $display("FAIL start_ignored: got %0d bad results %0d pulses want 0/1", bad, done_cnt);
    end
    run_job(2, 0, 0, -1, 0, -1, 3);
    @(negedge clk);
    rst = 0; a_valid_in = 0; b_valid_in = 0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({a_valid_out[0], b_valid_out[0], res_valid_out[0], done_out[0], busy_out[0],
         a_data_out[0], b_data_out[0], res40} !== 77'd0) begin
      n_err++;
      $display("FAIL abort_reset: got av %b bv %b rv %b done %b busy %b a %h b %h res %h want all 0",
               a_valid_out[0], b_valid_out[0], res_valid_out[0], done_out[0], busy_out[0],
               a_data_out[0], b_data_out[0], res40);
    end
    @(negedge clk);
    rst = 1;
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) begin qa.push_back(rnd16()); qb.push_back(rnd16()); end
    model_job();
    run_job(1, 0, 0, -1, 0, -1, -1);
    n_vec++;
    if (tmo !== 1'b0 || g40.size() != 4) begin
      n_err++; $display("FAIL fresh_count: got tmo %b results %0d want 0/4", tmo, g40.size());
    end
    for (int i = 0; i < 4 && i < int'(g40.size()); i++) begin
      n_vec++;
      if (gidx[i] !== i || g40[i] !== e40[i] || gs[i] !== es[i] || gw[i] !== ew[i]) begin
        n_err++;
        $display("FAIL fresh_res[%0d]: got idx %0d %0d/%0d/%0d want idx %0d %0d/%0d/%0d", i, gidx[i],
                 g40[i], gs[i], gw[i], i, e40[i], es[i], ew[i]);
      end
    end
  endtask

  task automatic test_random();
    int k, bad;
    for (int j = 0; j < 6; j++) begin
      k = $urandom_range(1, 4);
      qa.delete(); qb.delete();
      for (int i = 0; i < 4 * k; i++) begin qa.push_back(rnd16()); qb.push_back(rnd16()); end
      model_job();
      run_job(k, 1, 2, -1, 0, -1, -1);
      bad = (fa.size() != qa.size() || fb.size() != qb.size() || g40.size() != 4) ? 1 : 0;
      for (int i = 0; i < int'(fa.size()) && i < int'(qa.size()); i++) if (fa[i] != qa[i]) bad++;
      for (int i = 0; i < int'(fb.size()) && i < int'(qb.size()); i++) if (fb[i] != qb[i]) bad++;
      n_vec++;
      if (tmo !== 1'b0 || bad !== 0 || prot_err !== 0 || done_cnt !== 1) begin
        n_err++;
        $display("FAIL rand%0d_proto: got tmo %b fwd_bad %0d prot %0d pulses %0d want 0/0/0/1",
                 j, tmo, bad, prot_err, done_cnt);
      end
      for (int i = 0; i < 4 && i < int'(g40.size()); i++) begin
        n_vec++;
        if (gidx[i] !== i || g40[i] !== e40[i] || gs[i] !== es[i] || gw[i] !== ew[i]) begin
          n_err++;
          $display("FAIL rand%0d_res[%0d]: got idx %0d %0d/%0d/%0d want idx %0d %0d/%0d/%0d", j, i,
                   gidx[i], g40[i], gs[i], gw[i], i, e40[i], es[i], ew[i]);
        end
      end
      n_vec++;
      if (overflow_out[0] !== eo40 || overflow_out[1] !== eos || overflow_out[2] !== eow) begin
        n_err++;
        $display("FAIL rand%0d_ovf: got %b%b%b want %b%b%b", j, overflow_out[0], overflow_out[1],
                 overflow_out[2], eo40, eos, eow);
      end
    end
  endtask

  initial begin
    rst = 0; start_in = 0; k_in = '0; a_data_in = '0; b_data_in = '0;
    a_valid_in = 0; b_valid_in = 0; a_ready_in = 1; b_ready_in = 1; res_ready_in = 0;
    test_reset();
    test_k1_directed();
    test_back_to_back();
    test_stall();
    test_saturate();
    test_k0();
    test_start_ignored_and_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
